// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and default word width.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data path of the UART transmitter: load/shift register, bit counter and parity bit.
// The parity bit is computed once, from the word captured on load.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  ser_bit,
  output logic                  last_bit,
  output logic                  par_bit
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] sh_q;
  logic [CW-1:0]         cnt_q;
  logic                  primed_q;
  logic                  par_q;

  // The first shift only moves bit 0 onto the line, so the counter starts
  // advancing from the second shift and always names the bit being driven.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q     <= '0;
      cnt_q    <= '0;
      primed_q <= 1'b0;
      par_q    <= 1'b0;
    end else if (load) begin
      sh_q     <= data;
      cnt_q    <= '0;
      primed_q <= 1'b0;
      par_q    <= (par_typ == PAR_ODD) ? ~^data : ^data;
    end else if (shift) begin
      sh_q     <= sh_q >> 1;
      primed_q <= 1'b1;
      if (primed_q) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ser_bit  = sh_q[0];
  assign last_bit = (cnt_q == CW'(DATA_WIDTH - 1));
  assign par_bit  = par_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// One bit per CLK cycle; TX_OUT and BUSY are registered from the next state.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic [2:0]            dbg_state
);

  // Handshake: a word is accepted on a rising CLK edge where DATA_VALID=1 and
  // BUSY=0; DATA_VALID while BUSY=1 is dropped, never queued.

  uart_state_e state_q, state_d;
  logic        tx_d;
  logic        busy_d;
  logic        par_en_q;
  logic        accept;
  logic        load;
  logic        shift;
  logic        ser_bit;
  logic        last_bit;
  logic        par_bit;

  assign accept = DATA_VALID && !BUSY;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE:   if (accept) state_d = START;
      START:  state_d = DATA;
      DATA:   if (last_bit) state_d = par_en_q ? PARITY : STOP;
      PARITY: state_d = STOP;
      STOP:   state_d = accept ? START : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == START) load = 1'b1;
    shift  = (state_d == DATA);
    busy_d = (state_d == START) || (state_d == DATA) || (state_d == PARITY);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = ser_bit;
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      BUSY     <= 1'b0;
      TX_OUT   <= 1'b1;
      par_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      BUSY    <= busy_d;
      TX_OUT  <= tx_d;
      if (load) par_en_q <= PAR_EN;
    end
  end

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk      (CLK),
    .rst      (RST),
    .load     (load),
    .shift    (shift),
    .data     (P_DATA),
    .par_typ  (PAR_TYP),
    .ser_bit  (ser_bit),
    .last_bit (last_bit),
    .par_bit  (par_bit)
  );

  assign dbg_state = state_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter paired with top_RX_module. It accepts a parallel word through a valid/busy handshake and serialises it onto TX_OUT, one bit per CLK cycle. CLK is the bit-rate clock, i.e. the RX oversampling clock divided by Prescale. Frame format is start bit, DATA_WIDTH data bits LSB first, an optional parity bit, and one stop bit. Parity semantics match the receiver.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (the bit counter is sized as clog2(DATA_WIDTH)).

Ports:
CLK  input  1  bit-rate clock; all state changes on the rising edge.
RST  input  1  asynchronous, active-high reset.
P_DATA  input  DATA_WIDTH  parallel word to send; sampled only on accept.
DATA_VALID  input  1  request to send P_DATA.
PAR_EN  input  1  1 = insert parity bit; sampled on accept.
PAR_TYP  input  1  0 = even parity (bit = ^data), 1 = odd parity (bit = ~^data); sampled on accept.
TX_OUT  output  1  serial line, idle high; driven directly from a flop.
BUSY  output  1  high while the block cannot accept a word.

Behaviour:
- Reset (async, RST=1):
  - TX_OUT=1, BUSY=0, FSM=IDLE.
  - Shift register, bit counter and latched config are cleared.
  - Reset mid-frame aborts the frame immediately; the line returns high with no partial stop bit.
- Accept: occurs on a rising edge where DATA_VALID=1 and BUSY=0.
  - P_DATA, PAR_EN and PAR_TYP are latched.
  - The parity bit is computed from the latched data at accept.
  - Input changes after accept have no effect on the frame in flight.
- BUSY is a registered function of the next state: 0 in IDLE and STOP, 1 in START, DATA and PARITY.
- FSM states: IDLE, START, DATA, PARITY, STOP. TX_OUT value per state is 1, 0, shift-reg LSB, parity bit, 1 respectively.
  - IDLE -> START on accept. Otherwise stay.
  - START -> DATA after 1 cycle. The bit counter is cleared.
  - DATA: shift right each cycle. -> PARITY when counter = DATA_WIDTH-1 and PAR_EN latched = 1. -> STOP when counter = DATA_WIDTH-1 and PAR_EN latched = 0.
  - PARITY -> STOP after 1 cycle.
  - STOP -> START if accept occurs in this cycle (back-to-back, no idle gap). Otherwise -> IDLE.
- Latency: the start bit appears on TX_OUT in the cycle immediately after the accept edge.
- Frame length: 10 cycles without parity, 11 cycles with parity.
- DATA_VALID held high continuously produces back-to-back frames with exactly one stop bit between them.
- DATA_VALID while BUSY=1 is ignored. It is not queued, and there is no error flag.
- TX_OUT must never glitch. It changes only on CLK edges or on reset assertion.

Decomposition:
- Shared package (uart_pkg): state encodings (IDLE, START, DATA, PARITY, STOP), parity constants PAR_EVEN=1'b0 and PAR_ODD=1'b1, and the default DATA_WIDTH. The receiver uses the same package.
- Sub-module uart_tx_serializer:
  - Contains the load/shift register, bit counter and parity computation.
  - Inputs: load, shift.
  - Outputs: ser_bit, last_bit, par_bit.
- uart_tx itself keeps the FSM, the BUSY flop and the TX_OUT output mux flop.

Test Plan:
- Reset: RST=1 for 3 cycles mid-frame -> TX_OUT=1 and BUSY=0 immediately. After RST=0 with DATA_VALID=0, the line stays high for 5 cycles.
- No parity: P_DATA=8'hA5, PAR_EN=0, one-cycle DATA_VALID -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1. BUSY high for the 9 cycles START..DATA, then IDLE.
- Even parity: P_DATA=8'h3C, PAR_EN=1, PAR_TYP=0 -> data bits 0,0,1,1,1,1,0,0, parity 0, stop 1.
- Odd parity: P_DATA=8'h01, PAR_TYP=1 -> parity bit 0. With P_DATA=8'h00 -> parity bit 1.
- Back-to-back: DATA_VALID held high with 8'h55 then 8'hFF, PAR_EN=0 -> second start bit directly follows the first stop bit. Total 20 cycles, no idle cycle.
- Loopback: TX_OUT connected to top_RX_module with Prescale 8, 16 and 32, random data, random PAR_EN/PAR_TYP, 100 frames -> RX P_DATA equals the sent word on every DATA_VALID, with par_err=0 and stp_err=0.
